// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and constants for the binary-to-BCD converter
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } bcd_state_e;

  localparam int BCD_DIGIT_W    = 4;
  localparam int BCD_ADJ_THRESH = 5;
  localparam int BCD_ADJ_ADD    = 3;

  // True when DIGITS decimal digits can represent every IN_WIDTH-bit value.
  function automatic bit digits_cover(input int in_w, input int digits);
    longint unsigned max_val;
    longint unsigned pow10;
    max_val = (64'd1 << in_w) - 64'd1;
    pow10   = 64'd1;
    for (int i = 0; i < digits; i++) begin
      if (pow10 <= max_val) pow10 = pow10 * 64'd10;
    end
    return pow10 > max_val;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// rtl/bcd_digit_adjust.sv - double-dabble add-3 correction for one BCD digit
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] adjusted
);

  always_comb begin
    adjusted = digit;
    if (digit >= BCD_DIGIT_W'(BCD_ADJ_THRESH)) begin
      adjusted = digit + BCD_DIGIT_W'(BCD_ADJ_ADD);
    end
  end

endmodule

// File: rtl/product_bcd_converter.sv
// rtl/product_bcd_converter.sv - sequential shift/add-3 binary-to-BCD converter
module product_bcd_converter
  import bcd_pkg::*;
#(
  parameter int IN_WIDTH = 8,
  parameter int DIGITS   = 3
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic [IN_WIDTH-1:0]           product,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  output logic                          busy,
  output logic                          done
);

  localparam int SW    = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(IN_WIDTH + 1);

  generate
    if (!digits_cover(IN_WIDTH, DIGITS)) begin : g_bad_digits
      $error("product_bcd_converter: DIGITS too small for IN_WIDTH");
    end
  endgenerate

  bcd_state_e           state;
  bcd_state_e           state_next;
  logic [CNT_W-1:0]     cnt;
  logic [SW-1:0]        scratch;
  logic [SW-1:0]        adj_scratch;
  logic [SW-1:0]        scratch_shift;
  logic [IN_WIDTH-1:0]  bin;
  logic [IN_WIDTH-1:0]  bin_shift;
  logic                 last_iter;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit    (scratch[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .adjusted (adj_scratch[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Correct first, then shift {scratch, bin} left with bin's MSB entering scratch.
  assign scratch_shift = {adj_scratch[SW-2:0], bin[IN_WIDTH-1]};
  assign bin_shift     = {bin[IN_WIDTH-2:0], 1'b0};
  assign last_iter     = (cnt == CNT_W'(IN_WIDTH - 1));

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CONVERT;
      CONVERT: if (last_iter) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status flags are registered from the next state so they align with it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      scratch <= '0;
      bin     <= '0;
      bcd     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == CONVERT);
      done  <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            bin     <= product;
            scratch <= '0;
            cnt     <= '0;
          end
        end
        CONVERT: begin
          scratch <= scratch_shift;
          bin     <= bin_shift;
          cnt     <= cnt + CNT_W'(1);
          if (last_iter) bcd <= scratch_shift;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_product_bcd_converter.sv
// tb/tb_product_bcd_converter.sv - directed self-checking bench for product_bcd_converter
module tb_product_bcd_converter;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [7:0]  product;
  logic [11:0] bcd;
  logic        busy;
  logic        done;

  int passed = 0;
  int total  = 0;

  product_bcd_converter #(.IN_WIDTH(8), .DIGITS(3)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .product (product),
    .bcd     (bcd),
    .busy    (busy),
    .done    (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Caller sits at a negedge in IDLE; returns at the negedge where done is seen.
  task automatic run_conv(input logic [7:0] p, output int cycles, output int busy_cnt,
                          output bit overlap);
    product = p;
    start   = 1'b1;
    tick();
    start    = 1'b0;
    cycles   = -1;
    busy_cnt = 0;
    overlap  = 1'b0;
    for (int k = 0; k <= 20; k++) begin
      if (busy) busy_cnt++;
      if (busy && done) overlap = 1'b1;
      if (done) begin
        cycles = k;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start   = 1'b0;
    product = 8'd0;
    repeat (3) tick();
    total++;
    if ({bcd, busy, done} !== 14'd0) $display("FAIL reset_hold: got %h expected 0", {bcd, busy, done});
    else passed++;
    reset_n = 1'b1;
    repeat (2) tick();
    total++;
    if ({bcd, busy, done} !== 14'd0) $display("FAIL reset_release: got %h expected 0", {bcd, busy, done});
    else passed++;
  endtask

  task automatic test_single();
    int cyc, bc;
    bit ov;
    run_conv(8'd15, cyc, bc, ov);
    total++;
    if (cyc !== 8) $display("FAIL single_latency: got %0d expected 8", cyc);
    else passed++;
    total++;
    if (bcd !== 12'h015) $display("FAIL single_bcd: got %h expected 015", bcd);
    else passed++;
    total++;
    if (bc !== 8) $display("FAIL single_busy_len: got %0d expected 8", bc);
    else passed++;
    total++;
    if (busy !== 1'b0 || ov) $display("FAIL single_busy_at_done: got %b expected 0", busy);
    else passed++;
    tick();
    total++;
    if (done !== 1'b0) $display("FAIL single_done_pulse: got %b expected 0", done);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int cyc, bc;
    bit ov;
    run_conv(8'd255, cyc, bc, ov);
    total++;
    if (bcd !== 12'h255 || cyc !== 8) $display("FAIL b2b_first: got %h/%0d expected 255/8", bcd, cyc);
    else passed++;
    product = 8'd0;
    start   = 1'b1;
    tick();
    total++;
    if (busy !== 1'b0 || done !== 1'b0) $display("FAIL b2b_ignored_in_done: got %b%b expected 00", busy, done);
    else passed++;
    tick();
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || bcd !== 12'h255) $display("FAIL b2b_accept: got %b/%h expected 1/255", busy, bcd);
    else passed++;
    cyc = -1;
    for (int k = 0; k <= 20; k++) begin
      if (done) begin cyc = k; break; end
      tick();
    end
    total++;
    if (bcd !== 12'h000 || cyc !== 8) $display("FAIL b2b_second: got %h/%0d expected 000/8", bcd, cyc);
    else passed++;
    tick();
  endtask

  task automatic test_start_held();
    int done_cnt;
    int second_accept;
    product       = 8'd100;
    start         = 1'b1;
    done_cnt      = 0;
    second_accept = -1;
    tick();
    for (int k = 0; k < 11; k++) begin
      if (done) begin
        done_cnt++;
        total++;
        if (bcd !== 12'h100 || k !== 8) $display("FAIL held_result: got %h at %0d expected 100 at 8", bcd, k);
        else passed++;
      end
      if (k > 8 && busy && second_accept < 0) second_accept = k;
      tick();
    end
    start = 1'b0;
    total++;
    if (done_cnt !== 1) $display("FAIL held_single_conv: got %0d expected 1", done_cnt);
    else passed++;
    total++;
    if (second_accept !== 10) $display("FAIL held_second_accept: got %0d expected 10", second_accept);
    else passed++;
    for (int k = 0; k <= 20 && !done; k++) tick();
    tick();
  endtask

  task automatic test_product_change();
    int cyc;
    product = 8'd42;
    start   = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    product = 8'd99;
    cyc = -1;
    for (int k = 3; k <= 20; k++) begin
      if (done) begin cyc = k; break; end
      tick();
    end
    total++;
    if (bcd !== 12'h042 || cyc !== 8) $display("FAIL single_sample: got %h/%0d expected 042/8", bcd, cyc);
    else passed++;
    tick();
  endtask

  task automatic test_mid_reset();
    int cyc, bc;
    bit ov;
    product = 8'd200;
    start   = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({bcd, busy, done} !== 14'd0) $display("FAIL async_reset: got %h expected 0", {bcd, busy, done});
    else passed++;
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    total++;
    if ({bcd, busy, done} !== 14'd0) $display("FAIL post_reset_idle: got %h expected 0", {bcd, busy, done});
    else passed++;
    run_conv(8'd77, cyc, bc, ov);
    total++;
    if (bcd !== 12'h077 || cyc !== 8) $display("FAIL after_reset_conv: got %h/%0d expected 077/8", bcd, cyc);
    else passed++;
    tick();
  endtask

  task automatic test_sweep();
    int cyc, bc;
    bit ov;
    logic [11:0] exp_bcd;
    for (int v = 0; v < 256; v++) begin
      exp_bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
      run_conv(8'(v), cyc, bc, ov);
      total++;
      if (bcd !== exp_bcd || cyc !== 8 || ov)
        $display("FAIL sweep_%0d: got %h/%0d/%b expected %h/8/0", v, bcd, cyc, ov, exp_bcd);
      else passed++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_start_held();
    test_product_change();
    test_mid_reset();
    test_sweep();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
